// File: rtl/has_alert_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// has_pkg
// Shared definitions for the home-automation alert scheduler:
//   - requester index constants (front door .. temperature)
//   - DISP_IDLE, the display code shown when no source holds the resource
//   - state_e, the scheduler FSM state encoding
// -----------------------------------------------------------------------------
package has_pkg;

    localparam int IDX_FDOOR  = 0;
    localparam int IDX_RDOOR  = 1;
    localparam int IDX_WINDOW = 2;
    localparam int IDX_FIRE   = 3;
    localparam int IDX_TEMP   = 4;

    localparam logic [2:0] DISP_IDLE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/has_alert_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// has_rr_pick
// Combinational round-robin picker: finds the first set bit of pend, searching
// upward from ptr and wrapping from NREQ-1 back to 0.
//   pend  : pending request vector
//   ptr   : search start index (always < NREQ)
//   pick  : one-hot of the chosen requester (all zero if pend is empty)
//   idx   : binary index of the chosen requester (0 if pend is empty)
// -----------------------------------------------------------------------------
module has_rr_pick #(
    parameter int NREQ = 5,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pend,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx
);

    logic          found;
    logic [IW-1:0] pos;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IW'((int'(ptr) + k) % NREQ);
            if (!found && pend[pos]) begin
                found     = 1'b1;
                pick[pos] = 1'b1;
                idx       = pos;
            end
        end
    end

endmodule

// File: rtl/has_alert_scheduler.sv
// -----------------------------------------------------------------------------
// has_alert_scheduler
// Grants the shared display/buzzer resource to one of NREQ sensor sources at a
// time for HOLD_CYCLES cycles, followed by a one-cycle dead gap. The priority
// source (fire alarm) may take up to PRIO_MAX consecutive grants ahead of the
// round-robin order before round-robin must be honoured.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active low
//   en       : enable; low blocks new grants, a running grant completes
//   req      : level requests, latched into a pending register
//   grant    : one-hot registered grant, zero when idle/gap
//   display  : granted index, DISP_IDLE when no grant
//   buzz     : high while the priority source is granted
//   done     : pulse on the last hold cycle of a grant
//   busy     : high during GRANT and GAP
// -----------------------------------------------------------------------------
module has_alert_scheduler
    import has_pkg::*;
#(
    parameter int NREQ        = 5,
    parameter int HOLD_CYCLES = 4,
    parameter int PRIO_IDX    = IDX_FIRE,
    parameter int PRIO_MAX    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      display,
    output logic            buzz,
    output logic            done,
    output logic            busy
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = 8;
    // +2 keeps the width non-zero even for PRIO_MAX = 0
    localparam int PW = $clog2(PRIO_MAX + 2);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PRIO_LIM  = PW'(PRIO_MAX);

    state_e          state_q, state_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   prio_q, prio_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [2:0]      display_q, display_d;
    logic            buzz_q, buzz_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] clr;
    logic            arb;
    logic [NREQ-1:0] rr_pick;
    logic [IW-1:0]   rr_idx;

    has_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .pend (pend_q),
        .ptr  (ptr_q),
        .pick (rr_pick),
        .idx  (rr_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        prio_d    = prio_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        display_d = display_q;
        clr       = '0;
        arb       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_q == '0) begin
                    prio_d = '0;
                end else if (en) begin
                    arb = 1'b1;
                end
            end
            ST_GRANT: begin
                if (hold_q == HOLD_LAST) begin
                    clr       = grant_q;
                    state_d   = ST_GAP;
                    hold_d    = '0;
                    grant_d   = '0;
                    display_d = DISP_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (pend_q == '0) begin
                    prio_d  = '0;
                    state_d = ST_IDLE;
                end else if (en) begin
                    arb = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                grant_d   = '0;
                display_d = DISP_IDLE;
                hold_d    = '0;
            end
        endcase

        if (arb) begin
            state_d = ST_GRANT;
            hold_d  = '0;
            if (pend_q[PRIO_IDX] && (prio_q < PRIO_LIM)) begin
                // Priority bypass: round-robin pointer is left untouched
                grant_d   = NREQ'(1) << PRIO_IDX;
                display_d = 3'(PRIO_IDX);
                prio_d    = prio_q + 1'b1;
            end else begin
                grant_d   = rr_pick;
                display_d = 3'(rr_idx);
                ptr_d     = (rr_idx == IW'(NREQ - 1)) ? '0 : rr_idx + 1'b1;
                prio_d    = '0;
            end
        end

        // A request arriving on the clearing cycle re-queues the source
        pend_d = (pend_q & ~clr) | req;

        buzz_d = grant_d[PRIO_IDX];
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_GRANT) && (hold_d == HOLD_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            ptr_q     <= '0;
            prio_q    <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            display_q <= DISP_IDLE;
            buzz_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            prio_q    <= prio_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            display_q <= display_d;
            buzz_q    <= buzz_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign grant   = grant_q;
    assign display = display_q;
    assign buzz    = buzz_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule
